// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bus_arbiter
//  Purpose  : Round-robin owner arbiter for the BrainForge8 system bus
//             (core = 0, DMA = 1) with the external BR/BA ownership handshake.
//  Revision : 1.0  initial release
// ============================================================================
module bus_arbiter #(
    parameter int MAX_HOLD   = 8,
    parameter int BA_TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req0_i,
    input  logic lock0_i,
    output logic gnt0_o,
    input  logic req1_i,
    input  logic lock1_i,
    output logic gnt1_o,
    output logic br_o,
    input  logic ba_i,
    output logic dt_o,
    output logic owner_o,
    output logic tout_o
);

    localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam int WAIT_W = (BA_TIMEOUT > 2) ? $clog2(BA_TIMEOUT) : 1;

    localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(MAX_HOLD - 1);
    localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(BA_TIMEOUT - 1);

    localparam logic [2:0] c_s_idle    = 3'd0;
    localparam logic [2:0] c_s_request = 3'd1;
    localparam logic [2:0] c_s_grant0  = 3'd2;
    localparam logic [2:0] c_s_grant1  = 3'd3;
    localparam logic [2:0] c_s_handoff = 3'd4;

    generate
        if (MAX_HOLD < 2) begin : g_bad_max_hold
            $error("bus_arbiter: MAX_HOLD must be at least 2");
        end
        if (BA_TIMEOUT < 2) begin : g_bad_ba_timeout
            $error("bus_arbiter: BA_TIMEOUT must be at least 2");
        end
    endgenerate

    logic [2:0]        state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              owner_q, owner_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              br_q, br_d;
    logic              tout_q, tout_d;

    logic       w_any_req;
    logic       w_winner;
    logic [2:0] w_win_state;
    logic       w_timeout;

    // With both pending the previous owner yields; a lone requester always wins.
    assign w_any_req   = req0_i | req1_i;
    assign w_winner    = (req0_i & req1_i) ? ~owner_q : req1_i;
    assign w_win_state = w_winner ? c_s_grant1 : c_s_grant0;
    assign w_timeout   = (state_q == c_s_request) && w_any_req && !ba_i
                         && (wait_cnt_q == c_wait_last);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= c_s_idle;
            hold_cnt_q <= '0;
            wait_cnt_q <= '0;
            owner_q    <= 1'b1;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            br_q       <= 1'b0;
            tout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            owner_q    <= owner_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            br_q       <= br_d;
            tout_q     <= tout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_s_idle: begin
                if (w_any_req) state_d = c_s_request;
            end
            c_s_request: begin
                if (!w_any_req)     state_d = c_s_idle;
                else if (ba_i)      state_d = w_win_state;
                else if (w_timeout) state_d = c_s_idle;
            end
            c_s_grant0: begin
                if (!ba_i)        state_d = c_s_request;
                else if (!req0_i) state_d = c_s_handoff;
                else if ((hold_cnt_q == c_hold_last) && req1_i && !lock0_i)
                    state_d = c_s_handoff;
            end
            c_s_grant1: begin
                if (!ba_i)        state_d = c_s_request;
                else if (!req1_i) state_d = c_s_handoff;
                else if ((hold_cnt_q == c_hold_last) && req0_i && !lock1_i)
                    state_d = c_s_handoff;
            end
            c_s_handoff: begin
                if (!w_any_req) state_d = c_s_idle;
                else if (ba_i)  state_d = w_win_state;
                else            state_d = c_s_request;
            end
            default: state_d = c_s_idle;
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight off a flop.
    always_comb begin
        gnt0_d  = (state_d == c_s_grant0);
        gnt1_d  = (state_d == c_s_grant1);
        br_d    = (state_d != c_s_idle);
        tout_d  = w_timeout;
        owner_d = owner_q;
        if (state_d == c_s_grant0) owner_d = 1'b0;
        if (state_d == c_s_grant1) owner_d = 1'b1;

        hold_cnt_d = '0;
        if (gnt0_d || gnt1_d) begin
            if (state_d == state_q) begin
                hold_cnt_d = (hold_cnt_q == c_hold_last) ? hold_cnt_q
                                                         : hold_cnt_q + HOLD_W'(1);
            end
        end

        wait_cnt_d = '0;
        if ((state_q == c_s_request) && (state_d == c_s_request))
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end

    assign gnt0_o  = gnt0_q;
    assign gnt1_o  = gnt1_q;
    assign dt_o    = gnt1_q;
    assign br_o    = br_q;
    assign owner_o = owner_q;
    assign tout_o  = tout_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_arbiter
//  Purpose  : Directed self-checking bench for bus_arbiter (MAX_HOLD=8, BA_TIMEOUT=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic req0 = 1'b0, lock0 = 1'b0, req1 = 1'b0, lock1 = 1'b0, ba = 1'b0;
    logic gnt0, gnt1, br, dt, owner, tout;

    int checks = 0;
    int errors = 0;

    // Observation vector: {GNT0, GNT1, DT, BR, TOUT, OWNER}
    logic [5:0] obs;
    assign obs = {gnt0, gnt1, dt, br, tout, owner};

    bus_arbiter #(
        .MAX_HOLD   (8),
        .BA_TIMEOUT (4)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .req0_i  (req0),
        .lock0_i (lock0),
        .gnt0_o  (gnt0),
        .req1_i  (req1),
        .lock1_i (lock1),
        .gnt1_o  (gnt1),
        .br_o    (br),
        .ba_i    (ba),
        .dt_o    (dt),
        .owner_o (owner),
        .tout_o  (tout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        checks++;
        if (obs !== 6'b000001) begin
            errors++;
            $display("FAIL reset_init obs=%b exp=%b", obs, 6'b000001);
        end
        rst = 1'b0;
        ba = 1'b1; req1 = 1'b1;
        step();
        step();
        checks++;
        if (obs !== 6'b011101) begin
            errors++;
            $display("FAIL pre_reset_grant1 obs=%b exp=%b", obs, 6'b011101);
        end
        rst = 1'b1;
        #2;
        checks++;
        if (obs !== 6'b000001) begin
            errors++;
            $display("FAIL async_reset obs=%b exp=%b", obs, 6'b000001);
        end
        req1 = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_single();
        ba = 1'b1; req0 = 1'b1;
        step();
        checks++;
        if (obs !== 6'b000101) begin
            errors++;
            $display("FAIL single_br obs=%b exp=%b", obs, 6'b000101);
        end
        step();
        checks++;
        if (obs !== 6'b100100) begin
            errors++;
            $display("FAIL single_gnt obs=%b exp=%b", obs, 6'b100100);
        end
        req0 = 1'b0;
        step();
        checks++;
        if (obs !== 6'b000100) begin
            errors++;
            $display("FAIL single_release obs=%b exp=%b", obs, 6'b000100);
        end
        step();
        checks++;
        if (obs !== 6'b000000) begin
            errors++;
            $display("FAIL single_idle obs=%b exp=%b", obs, 6'b000000);
        end
    endtask

    task automatic test_round_robin();
        rst = 1'b1;
        step();
        rst = 1'b0;
        ba = 1'b1; req0 = 1'b1; req1 = 1'b1;
        step();
        checks++;
        if (obs !== 6'b000101) begin
            errors++;
            $display("FAIL rr_request obs=%b exp=%b", obs, 6'b000101);
        end
        step();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs !== 6'b100100) begin
                errors++;
                $display("FAIL rr_gnt0 cycle=%0d obs=%b exp=%b", i, obs, 6'b100100);
            end
            step();
        end
        checks++;
        if (obs !== 6'b000100) begin
            errors++;
            $display("FAIL rr_dead0 obs=%b exp=%b", obs, 6'b000100);
        end
        step();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs !== 6'b011101) begin
                errors++;
                $display("FAIL rr_gnt1 cycle=%0d obs=%b exp=%b", i, obs, 6'b011101);
            end
            step();
        end
        checks++;
        if (obs !== 6'b000101) begin
            errors++;
            $display("FAIL rr_dead1 obs=%b exp=%b", obs, 6'b000101);
        end
        step();
        checks++;
        if (obs !== 6'b100100) begin
            errors++;
            $display("FAIL rr_gnt0_again obs=%b exp=%b", obs, 6'b100100);
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
        step();
        checks++;
        if (obs !== 6'b000000) begin
            errors++;
            $display("FAIL rr_idle obs=%b exp=%b", obs, 6'b000000);
        end
    endtask

    task automatic test_lock();
        ba = 1'b1; req0 = 1'b1; lock0 = 1'b1;
        step();
        step();
        checks++;
        if (obs !== 6'b100100) begin
            errors++;
            $display("FAIL lock_grant obs=%b exp=%b", obs, 6'b100100);
        end
        req1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (obs !== 6'b100100) begin
                errors++;
                $display("FAIL lock_hold cycle=%0d obs=%b exp=%b", i, obs, 6'b100100);
            end
        end
        lock0 = 1'b0;
        step();
        checks++;
        if (obs !== 6'b000100) begin
            errors++;
            $display("FAIL lock_release obs=%b exp=%b", obs, 6'b000100);
        end
        step();
        checks++;
        if (obs !== 6'b011101) begin
            errors++;
            $display("FAIL lock_gnt1 obs=%b exp=%b", obs, 6'b011101);
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
        step();
        checks++;
        if (obs !== 6'b000001) begin
            errors++;
            $display("FAIL lock_idle obs=%b exp=%b", obs, 6'b000001);
        end
    endtask

    task automatic test_timeout();
        ba = 1'b0; req1 = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs !== 6'b000101) begin
                errors++;
                $display("FAIL tout_br cycle=%0d obs=%b exp=%b", i, obs, 6'b000101);
            end
            step();
        end
        checks++;
        if (obs !== 6'b000011) begin
            errors++;
            $display("FAIL tout_pulse obs=%b exp=%b", obs, 6'b000011);
        end
        step();
        checks++;
        if (obs !== 6'b000101) begin
            errors++;
            $display("FAIL tout_rerise obs=%b exp=%b", obs, 6'b000101);
        end
        step();
        step();
        step();
        checks++;
        if (obs !== 6'b000101) begin
            errors++;
            $display("FAIL tout_last_wait obs=%b exp=%b", obs, 6'b000101);
        end
        ba = 1'b1;
        step();
        checks++;
        if (obs !== 6'b011101) begin
            errors++;
            $display("FAIL tout_ba_wins obs=%b exp=%b", obs, 6'b011101);
        end
    endtask

    task automatic test_ba_drop();
        step();
        step();
        checks++;
        if (obs !== 6'b011101) begin
            errors++;
            $display("FAIL badrop_pre obs=%b exp=%b", obs, 6'b011101);
        end
        ba = 1'b0;
        step();
        checks++;
        if (obs !== 6'b000101) begin
            errors++;
            $display("FAIL badrop_fall obs=%b exp=%b", obs, 6'b000101);
        end
        ba = 1'b1;
        step();
        checks++;
        if (obs !== 6'b011101) begin
            errors++;
            $display("FAIL badrop_regrant obs=%b exp=%b", obs, 6'b011101);
        end
        req0 = 1'b1;
        for (int i = 1; i < 8; i++) begin
            step();
            checks++;
            if (obs !== 6'b011101) begin
                errors++;
                $display("FAIL badrop_hold cycle=%0d obs=%b exp=%b", i, obs, 6'b011101);
            end
        end
        step();
        checks++;
        if (obs !== 6'b000101) begin
            errors++;
            $display("FAIL badrop_forced obs=%b exp=%b", obs, 6'b000101);
        end
        step();
        checks++;
        if (obs !== 6'b100100) begin
            errors++;
            $display("FAIL badrop_gnt0 obs=%b exp=%b", obs, 6'b100100);
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
        step();
        checks++;
        if (obs !== 6'b000000) begin
            errors++;
            $display("FAIL final_idle obs=%b exp=%b", obs, 6'b000000);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_timeout();
        test_ba_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
